axilite_slave_bridge: RTL and testbench
=======================================

AXILITE_SLAVE_BRIDGE -- requirements
Module: axilite_slave_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, the number of cycles to wait for lcl_ack/lcl_dv before an error response (range 2..65535).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have AXI-Lite write address ports: s_axi_awvalid (in, 1), s_axi_awready (out, 1), s_axi_awaddr (in, 32), s_axi_awprot (in, 3, ignored).
REQ-005 SHALL have AXI-Lite write data ports: s_axi_wvalid (in, 1), s_axi_wready (out, 1), s_axi_wdata (in, 32), s_axi_wstrb (in, 4).
REQ-006 SHALL have AXI-Lite write response ports: s_axi_bvalid (out, 1), s_axi_bready (in, 1), s_axi_bresp (out, 2).
REQ-007 SHALL have AXI-Lite read address ports: s_axi_arvalid (in, 1), s_axi_arready (out, 1), s_axi_araddr (in, 32), s_axi_arprot (in, 3, ignored).
REQ-008 SHALL have AXI-Lite read data ports: s_axi_rvalid (out, 1), s_axi_rready (in, 1), s_axi_rdata (out, 32), s_axi_rresp (out, 2).
REQ-009 SHALL have local request ports: lcl_wr (out, 1, one-cycle write pulse), lcl_rd (out, 1, one-cycle read pulse), lcl_addr (out, 32), lcl_din (out, 32), lcl_wstrb (out, 4).
REQ-010 SHALL have local response ports: lcl_ack (in, 1, write done), lcl_dv (in, 1, read data valid), lcl_rsp (in, 1, 0=good/1=bad, sampled with ack or dv), lcl_dout (in, 32).

Function
REQ-011 SHALL capture AW and W independently in one-entry buffers; awready=1 iff the AW buffer is empty, wready=1 iff the W buffer is empty; either may arrive first.
REQ-012 SHALL deassert arready while an AR is buffered or a read is in progress.
REQ-013 SHALL use FSM states IDLE, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP; one local transaction at a time.
REQ-014 In IDLE with both write buffers full, SHALL pulse lcl_wr for exactly one cycle and enter WR_WAIT; lcl_addr/lcl_din/lcl_wstrb SHALL hold the buffered values from the pulse until the response completes.
REQ-015 Latency: if the last of the AW/W handshakes occurs in cycle T with the FSM in IDLE, lcl_wr SHALL be high in cycle T+1; likewise an AR handshake in cycle T SHALL produce lcl_rd in T+1.
REQ-016 In IDLE with an AR buffered, SHALL pulse lcl_rd, drive lcl_addr=araddr, and enter RD_WAIT.
REQ-017 If a write and a read are both ready in IDLE, SHALL serve the type not served last; after reset, writes have priority.
REQ-018 lcl_ack/lcl_dv SHALL be honoured only from the cycle after the pulse while in the matching WAIT state; at any other time they SHALL be ignored.
REQ-019 On lcl_ack in cycle A: bvalid=1 from A+1, bresp=2'b00 if lcl_rsp=0 else 2'b10 (SLVERR); state WR_RESP.
REQ-020 On lcl_dv in cycle D: rvalid=1 from D+1, rdata=lcl_dout sampled in D, rresp per lcl_rsp as in REQ-019; state RD_RESP.
REQ-021 bvalid/rvalid and their payload SHALL hold stable until bready/rready; on that handshake the FSM SHALL return to IDLE and the served buffers SHALL clear (ready re-asserts in the next cycle).
REQ-022 A 16-bit counter SHALL start at the pulse; if TIMEOUT_CYCLES cycles elapse without ack/dv, the block SHALL respond with SLVERR (rdata=32'hDEAD_DEAD for reads) and move to the RESP state.
REQ-023 Outputs not being driven by a transaction SHALL be 0: lcl_* strobes, bvalid, rvalid; bresp/rresp/rdata hold their last values.

Reset
REQ-024 rst_n low SHALL immediately force: FSM=IDLE, buffers empty, awready=wready=arready=0, bvalid=rvalid=0, lcl_wr=lcl_rd=0, lcl_addr/lcl_din/rdata=0, lcl_wstrb=0, bresp=rresp=0, counter=0, priority=write.
REQ-025 awready/wready/arready SHALL rise in the first clock edge after rst_n deasserts; reset mid-transaction SHALL discard it without a response.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, the RESP_OKAY/RESP_SLVERR constants and the 32'hDEAD_DEAD timeout read data.
REQ-027 The block SHALL be flat, with no sub-modules; buffer, FSM and timeout counter are inline.

Verification
REQ-028 AW(0x10) and W(0xA5A5_0001, strb 0xF) in the same cycle T -> lcl_wr in T+1 with addr 0x10; ack at T+3 -> bvalid at T+4, bresp 00.
REQ-029 W issued 3 cycles before AW -> no lcl_wr until the cycle after AW; exactly one pulse.
REQ-030 AR(0x20), lcl_dv with dout 0x1234_5678 and rsp=1 -> rvalid with rdata 0x1234_5678 and rresp 10; bready/rready held low 5 cycles -> payload stable.
REQ-031 Write and read both ready in IDLE after reset -> write served first, then read; repeat -> read served first.
REQ-032 TIMEOUT_CYCLES=8, no dv -> rvalid 8 cycles after lcl_rd, rresp 10, rdata 0xDEAD_DEAD; a late dv is ignored.
REQ-033 rst_n asserted during WR_WAIT -> all valids/readies 0 immediately; after release a new write completes normally.

Source files
------------

// File: rtl/axilite_slave_bridge_pkg.sv
// Shared definitions for the AXI-Lite to local-bus bridge: FSM encoding,
// AXI response codes and the read data returned on a local-bus timeout.
package axilite_slave_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_WAIT = 3'd1,
    WR_RESP = 3'd2,
    RD_WAIT = 3'd3,
    RD_RESP = 3'd4
  } state_e;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;

  function automatic logic [1:0] resp_of(input logic bad);
    return bad ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axilite_slave_bridge.sv
// AXI-Lite slave that serialises write and read requests onto a simple
// pulse/acknowledge local bus, with a per-transaction timeout.
module axilite_slave_bridge
  import axilite_slave_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  // write address
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awprot,
  // write data
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  // write response
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  // read address
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  // read data
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  // local request
  output logic        lcl_wr,
  output logic        lcl_rd,
  output logic [31:0] lcl_addr,
  output logic [31:0] lcl_din,
  output logic [3:0]  lcl_wstrb,
  // local response
  input  logic        lcl_ack,
  input  logic        lcl_dv,
  input  logic        lcl_rsp,
  input  logic [31:0] lcl_dout
);

  // Counter value seen in the last wait cycle before a timeout response.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      r_state;
  state_e      w_next;
  logic        r_ready_en;
  logic        r_aw_full;
  logic        r_w_full;
  logic        r_ar_full;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_araddr;
  logic        r_prio_rd;
  logic [15:0] r_cnt;
  logic [1:0]  r_bresp;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;

  logic w_wr_ready;
  logic w_rd_ready;
  logic w_start_wr;
  logic w_start_rd;
  logic w_timeout;
  logic w_b_hs;
  logic w_r_hs;
  logic w_sel_rd;
  logic w_unused;

  assign w_unused   = ^{s_axi_awprot, s_axi_arprot};

  assign w_wr_ready = r_aw_full & r_w_full;
  assign w_rd_ready = r_ar_full;
  assign w_timeout  = (r_cnt == TO_LAST);
  assign w_b_hs     = (r_state == WR_RESP) & s_axi_bready;
  assign w_r_hs     = (r_state == RD_RESP) & s_axi_rready;

  // Readies stay low until the first edge after reset release.
  assign s_axi_awready = r_ready_en & ~r_aw_full;
  assign s_axi_wready  = r_ready_en & ~r_w_full;
  assign s_axi_arready = r_ready_en & ~r_ar_full;

  assign s_axi_bvalid = (r_state == WR_RESP);
  assign s_axi_rvalid = (r_state == RD_RESP);
  assign s_axi_bresp  = r_bresp;
  assign s_axi_rresp  = r_rresp;
  assign s_axi_rdata  = r_rdata;

  assign lcl_wr    = w_start_wr;
  assign lcl_rd    = w_start_rd;
  assign w_sel_rd  = w_start_rd | (r_state == RD_WAIT) | (r_state == RD_RESP);
  assign lcl_addr  = w_sel_rd ? r_araddr : r_awaddr;
  assign lcl_din   = r_wdata;
  assign lcl_wstrb = r_wstrb;

  // NOTE: non-blocking assignments in clocked blocks so every flop samples
  // pre-edge values regardless of statement or process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, otherwise any
  // path that skips an assignment infers a latch.
  always_comb begin
    w_next     = r_state;
    w_start_wr = 1'b0;
    w_start_rd = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_wr_ready && !(w_rd_ready && r_prio_rd)) begin
          w_start_wr = 1'b1;
          w_next     = WR_WAIT;
        end else if (w_rd_ready) begin
          w_start_rd = 1'b1;
          w_next     = RD_WAIT;
        end
      end
      WR_WAIT: if (lcl_ack || w_timeout) w_next = WR_RESP;
      WR_RESP: if (s_axi_bready)         w_next = IDLE;
      RD_WAIT: if (lcl_dv || w_timeout)  w_next = RD_RESP;
      RD_RESP: if (s_axi_rready)         w_next = IDLE;
      default:                           w_next = IDLE;
    endcase
  end

  // NOTE: payload registers are reset too, because lcl_addr/lcl_din/lcl_wstrb
  // are visible outputs that must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
      r_aw_full  <= 1'b0;
      r_w_full   <= 1'b0;
      r_ar_full  <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_araddr   <= '0;
    end else begin
      r_ready_en <= 1'b1;
      if (s_axi_awvalid && s_axi_awready) begin
        r_aw_full <= 1'b1;
        r_awaddr  <= s_axi_awaddr;
      end else if (w_b_hs) begin
        r_aw_full <= 1'b0;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        r_w_full <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end else if (w_b_hs) begin
        r_w_full <= 1'b0;
      end
      if (s_axi_arvalid && s_axi_arready) begin
        r_ar_full <= 1'b1;
        r_araddr  <= s_axi_araddr;
      end else if (w_r_hs) begin
        r_ar_full <= 1'b0;
      end
    end
  end

  // Priority only flips when both request types actually competed, so
  // contended requests alternate while an uncontended one leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_rd <= 1'b0;
    end else if ((r_state == IDLE) && w_wr_ready && w_rd_ready) begin
      r_prio_rd <= w_start_wr;
    end
  end

  // Cycles elapsed since the request pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_start_wr || w_start_rd) begin
      r_cnt <= 16'd1;
    end else if ((r_state == WR_WAIT) || (r_state == RD_WAIT)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bresp <= RESP_OKAY;
      r_rresp <= RESP_OKAY;
      r_rdata <= '0;
    end else begin
      if (r_state == WR_WAIT) begin
        if (lcl_ack)        r_bresp <= resp_of(lcl_rsp);
        else if (w_timeout) r_bresp <= RESP_SLVERR;
      end
      if (r_state == RD_WAIT) begin
        if (lcl_dv) begin
          r_rresp <= resp_of(lcl_rsp);
          r_rdata <= lcl_dout;
        end else if (w_timeout) begin
          r_rresp <= RESP_SLVERR;
          r_rdata <= TIMEOUT_RDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_axilite_slave_bridge.sv
// Self-checking bench for axilite_slave_bridge: a table of single
// transactions plus directed sequences for latency, arbitration, timeout, reset.
module tb_axilite_slave_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_axi_awvalid = 1'b0, s_axi_awready;
  logic [31:0] s_axi_awaddr = '0;
  logic [2:0]  s_axi_awprot = '0;
  logic        s_axi_wvalid = 1'b0, s_axi_wready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_bvalid, s_axi_bready = 1'b0;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid = 1'b0, s_axi_arready;
  logic [31:0] s_axi_araddr = '0;
  logic [2:0]  s_axi_arprot = '0;
  logic        s_axi_rvalid, s_axi_rready = 1'b0;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        lcl_wr, lcl_rd;
  logic [31:0] lcl_addr, lcl_din;
  logic [3:0]  lcl_wstrb;
  logic        lcl_ack = 1'b0, lcl_dv = 1'b0, lcl_rsp = 1'b0;
  logic [31:0] lcl_dout = '0;

  int n_checks = 0;
  int n_errors = 0;

  axilite_slave_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .lcl_wr(lcl_wr), .lcl_rd(lcl_rd), .lcl_addr(lcl_addr),
    .lcl_din(lcl_din), .lcl_wstrb(lcl_wstrb),
    .lcl_ack(lcl_ack), .lcl_dv(lcl_dv), .lcl_rsp(lcl_rsp), .lcl_dout(lcl_dout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          lat;       // cycles after the pulse to respond; 0 = never
    logic        rsp;
    logic [31:0] dout;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; all DUT outputs are
  // register-derived so they are stable here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Current cycle is a WAIT state: give the local response now, then
  // check the AXI response and complete its handshake.
  task automatic respond_now(input bit is_rd, input logic rsp, input logic [31:0] dout,
                             input logic [1:0] exp_resp, input logic [31:0] exp_rdata,
                             input string name);
    if (is_rd) lcl_dv = 1'b1; else lcl_ack = 1'b1;
    lcl_rsp  = rsp;
    lcl_dout = dout;
    check({name, " valid before resp"}, is_rd ? s_axi_rvalid : s_axi_bvalid, 0);
    tick();
    lcl_dv  = 1'b0;
    lcl_ack = 1'b0;
    lcl_dout = 32'h0;
    finish_resp(is_rd, exp_resp, exp_rdata, name);
  endtask

  task automatic finish_resp(input bit is_rd, input logic [1:0] exp_resp,
                             input logic [31:0] exp_rdata, input string name);
    check({name, " valid"}, is_rd ? s_axi_rvalid : s_axi_bvalid, 1);
    check({name, " resp"}, is_rd ? s_axi_rresp : s_axi_bresp, exp_resp);
    if (is_rd) check({name, " rdata"}, s_axi_rdata, exp_rdata);
    if (is_rd) s_axi_rready = 1'b1; else s_axi_bready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    s_axi_bready = 1'b0;
    check({name, " valid drop"}, is_rd ? s_axi_rvalid : s_axi_bvalid, 0);
    check({name, " ready back"}, is_rd ? s_axi_arready : s_axi_awready, 1);
  endtask

  // Current cycle holds the request pulse.
  task automatic complete_resp(input vec_t v, input string name);
    int n;
    if (v.lat == 0) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!(v.is_rd ? s_axi_rvalid : s_axi_bvalid) && n < 4 * TO);
      check({name, " timeout latency"}, n, TO);
      finish_resp(v.is_rd, v.exp_resp, v.exp_rdata, name);
    end else begin
      repeat (v.lat) tick();
      respond_now(v.is_rd, v.rsp, v.dout, v.exp_resp, v.exp_rdata, name);
    end
  endtask

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    s_axi_awvalid = 1'b1; s_axi_awaddr = a;
    s_axi_wvalid  = 1'b1; s_axi_wdata  = d; s_axi_wstrb = s;
  endtask

  task automatic drive_read(input logic [31:0] a);
    s_axi_arvalid = 1'b1; s_axi_araddr = a;
  endtask

  task automatic drop_valids();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin : main
    int pulses;
    vec_t v;

    vecs[0] = '{is_rd:0, addr:32'h100, wdata:32'h1122_3344, strb:4'h3, lat:1, rsp:0,
                dout:32'h0, exp_resp:2'b00, exp_rdata:32'h0};
    vecs[1] = '{is_rd:1, addr:32'h200, wdata:32'h0, strb:4'h0, lat:2, rsp:0,
                dout:32'hCAFE_BABE, exp_resp:2'b00, exp_rdata:32'hCAFE_BABE};
    vecs[2] = '{is_rd:0, addr:32'h304, wdata:32'hFFFF_0000, strb:4'h8, lat:4, rsp:1,
                dout:32'h0, exp_resp:2'b10, exp_rdata:32'h0};
    vecs[3] = '{is_rd:1, addr:32'h40, wdata:32'h0, strb:4'h0, lat:6, rsp:1,
                dout:32'h0BAD_F00D, exp_resp:2'b10, exp_rdata:32'h0BAD_F00D};
    vecs[4] = '{is_rd:0, addr:32'h8, wdata:32'h5A5A_5A5A, strb:4'hF, lat:0, rsp:0,
                dout:32'h0, exp_resp:2'b10, exp_rdata:32'h0};
    vecs[5] = '{is_rd:1, addr:32'hFFFF_FFFC, wdata:32'h0, strb:4'h0, lat:1, rsp:0,
                dout:32'h0000_0000, exp_resp:2'b00, exp_rdata:32'h0};

    // Reset state, held across an edge
    tick();
    check("rst awready", s_axi_awready, 0);
    check("rst wready", s_axi_wready, 0);
    check("rst arready", s_axi_arready, 0);
    check("rst bvalid", s_axi_bvalid, 0);
    check("rst rvalid", s_axi_rvalid, 0);
    check("rst lcl_wr/rd", {lcl_wr, lcl_rd}, 0);
    check("rst lcl_addr", lcl_addr, 0);
    check("rst lcl_din", lcl_din, 0);
    check("rst lcl_wstrb", lcl_wstrb, 0);
    check("rst rdata", s_axi_rdata, 0);
    check("rst resps", {s_axi_bresp, s_axi_rresp}, 0);
    rst_n = 1'b1;
    tick();
    check("post-rst readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

    // AW and W together, ack two cycles after the pulse
    drive_write(32'h10, 32'hA5A5_0001, 4'hF);
    tick();
    drop_valids();
    check("basic lcl_wr", lcl_wr, 1);
    check("basic lcl_addr", lcl_addr, 32'h10);
    check("basic lcl_din", lcl_din, 32'hA5A5_0001);
    check("basic lcl_wstrb", lcl_wstrb, 4'hF);
    check("basic awready busy", s_axi_awready, 0);
    tick();
    check("basic single pulse", lcl_wr, 0);
    check("basic addr held", lcl_addr, 32'h10);
    tick();
    respond_now(0, 0, 32'h0, 2'b00, 32'h0, "basic");

    // W three cycles ahead of AW
    pulses = 0;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h0000_BEEF; s_axi_wstrb = 4'h1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      s_axi_wvalid = 1'b0;
      pulses += int'(lcl_wr);
    end
    check("w-first no early pulse", pulses, 0);
    check("w-first wready low", s_axi_wready, 0);
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h44;
    tick();
    s_axi_awvalid = 1'b0;
    check("w-first lcl_wr after aw", lcl_wr, 1);
    check("w-first lcl_addr", lcl_addr, 32'h44);
    check("w-first lcl_din", lcl_din, 32'h0000_BEEF);
    pulses = int'(lcl_wr);
    for (int k = 0; k < 2; k++) begin
      tick();
      pulses += int'(lcl_wr);
    end
    check("w-first one pulse", pulses, 1);
    respond_now(0, 0, 32'h0, 2'b00, 32'h0, "w-first");

    // Read with SLVERR, response held while rready low
    drive_read(32'h20);
    tick();
    drop_valids();
    check("rd lcl_rd", lcl_rd, 1);
    check("rd lcl_addr", lcl_addr, 32'h20);
    check("rd arready busy", s_axi_arready, 0);
    tick();
    lcl_dv = 1'b1; lcl_rsp = 1'b1; lcl_dout = 32'h1234_5678;
    tick();
    lcl_dv = 1'b0; lcl_rsp = 1'b0; lcl_dout = 32'hFFFF_FFFF;
    for (int k = 0; k < 5; k++) begin
      check("rd hold", {31'h0, s_axi_rvalid}, 1);
      check("rd hold rdata", s_axi_rdata, 32'h1234_5678);
      check("rd hold rresp", s_axi_rresp, 2'b10);
      tick();
    end
    finish_resp(1, 2'b10, 32'h1234_5678, "rd");

    // Table of single transactions
    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.is_rd) drive_read(v.addr);
      else drive_write(v.addr, v.wdata, v.strb);
      tick();
      drop_valids();
      check($sformatf("vec%0d pulse", i), {lcl_wr, lcl_rd}, v.is_rd ? 2'b01 : 2'b10);
      check($sformatf("vec%0d lcl_addr", i), lcl_addr, v.addr);
      if (!v.is_rd) begin
        check($sformatf("vec%0d lcl_din", i), lcl_din, v.wdata);
        check($sformatf("vec%0d lcl_wstrb", i), lcl_wstrb, v.strb);
      end
      complete_resp(v, $sformatf("vec%0d", i));
    end

    // Read timeout, late dv ignored
    drive_read(32'h60);
    tick();
    drop_valids();
    check("to lcl_rd", lcl_rd, 1);
    repeat (TO - 1) tick();
    check("to not yet", s_axi_rvalid, 0);
    tick();
    check("to rvalid", s_axi_rvalid, 1);
    lcl_dv = 1'b1; lcl_dout = 32'h5555_5555; lcl_rsp = 1'b0;
    tick();
    lcl_dv = 1'b0;
    finish_resp(1, 2'b10, 32'hDEAD_DEAD, "to late-dv");

    // Arbitration: write first after reset, then alternate on contention
    apply_reset();
    drive_write(32'h70, 32'h7777_0000, 4'hF);
    drive_read(32'h80);
    tick();
    drop_valids();
    check("arb1 write first", {lcl_wr, lcl_rd}, 2'b10);
    check("arb1 arready busy", s_axi_arready, 0);
    tick();
    respond_now(0, 0, 32'h0, 2'b00, 32'h0, "arb1 wr");
    check("arb1 then read", {lcl_wr, lcl_rd}, 2'b01);
    check("arb1 read addr", lcl_addr, 32'h80);
    tick();
    respond_now(1, 0, 32'h0000_0080, 2'b00, 32'h0000_0080, "arb1 rd");
    drive_write(32'h90, 32'h9999_0000, 4'h2);
    drive_read(32'hA0);
    tick();
    drop_valids();
    check("arb2 read first", {lcl_wr, lcl_rd}, 2'b01);
    check("arb2 read addr", lcl_addr, 32'hA0);
    tick();
    respond_now(1, 1, 32'h0000_00A0, 2'b10, 32'h0000_00A0, "arb2 rd");
    check("arb2 then write", {lcl_wr, lcl_rd}, 2'b10);
    check("arb2 write addr", lcl_addr, 32'h90);
    tick();
    respond_now(0, 0, 32'h0, 2'b00, 32'h0, "arb2 wr");

    // Reset during WR_WAIT
    drive_write(32'hB0, 32'hB0B0_B0B0, 4'hF);
    tick();
    drop_valids();
    check("mid-rst pulse", lcl_wr, 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid-rst readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
    check("mid-rst valids", {s_axi_bvalid, s_axi_rvalid}, 0);
    check("mid-rst strobes", {lcl_wr, lcl_rd}, 0);
    lcl_ack = 1'b1;
    tick();
    lcl_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    check("mid-rst readies back", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    check("mid-rst no stale bvalid", s_axi_bvalid, 0);
    drive_write(32'hC0, 32'hC0C0_0001, 4'h5);
    tick();
    drop_valids();
    check("post-rst wr pulse", lcl_wr, 1);
    check("post-rst wr addr", lcl_addr, 32'hC0);
    tick();
    respond_now(0, 0, 32'h0, 2'b00, 32'h0, "post-rst wr");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
